// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 Hz timing constants and the sync bundle type.
// The renderer imports the same package, so its 144/35 active-area offsets are
// named here instead of being repeated as literals.
package vga_timing_pkg;

    localparam int CNT_W       = 10;
    localparam int FRAME_CNT_W = 16;

    // Default 640x480@60 Hz timing (pixels / lines)
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;

    localparam int H_TOTAL     = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;   // 800
    localparam int V_TOTAL     = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;   // 525
    localparam int H_ACT_START = DEF_H_SYNC + DEF_H_BP;                             // 144
    localparam int V_ACT_START = DEF_V_SYNC + DEF_V_BP;                             // 35
    localparam int H_ACT_END   = H_ACT_START + DEF_H_ACTIVE - 1;                    // 783
    localparam int V_ACT_END   = V_ACT_START + DEF_V_ACTIVE - 1;                    // 514

    // Strobes that travel together through the alignment pipeline
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    // Idle level: syncs inactive (high), blanked
    localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH x WIDTH shift register with a per-bit reset value.
// DEPTH=0 is a straight wire.
// Ports: VGA_CLK clock, reset async active-high, din in, dout = din DEPTH cycles ago.
module vga_sync_delay #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             VGA_CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = VGA_CLK ^ reset;
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] stage;

            always_ff @(posedge VGA_CLK or posedge reset) begin
                if (reset) begin
                    stage <= {DEPTH{RST_VAL}};
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raw scan counters plus sync/blank strobes for 640x480@60 Hz VGA.
// Ports:
//   VGA_CLK      pixel clock
//   reset        asynchronous, active-high
//   VGA_X/VGA_Y  raw h/v counters (0..H_TOTAL-1 / 0..V_TOTAL-1)
//   VGA_HS/VS    active-low syncs, delayed PIPE_DELAY cycles
//   VGA_BLANK_N  high in the visible region, delayed PIPE_DELAY cycles
//   VGA_SYNC_N   tied 0 (sync-on-green unused)
//   frame_tick   one-cycle pulse at (0, V_ACT_END+1), not delayed
//   frame_count  frame counter when VGA_FRAME_COUNT_EN is defined, else 0
// Optional feature macro: VGA_FRAME_COUNT_EN.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int PIPE_DELAY = 1
) (
    input  logic                   VGA_CLK,
    input  logic                   reset,
    output logic [CNT_W-1:0]       VGA_X,
    output logic [CNT_W-1:0]       VGA_Y,
    output logic                   VGA_HS,
    output logic                   VGA_VS,
    output logic                   VGA_BLANK_N,
    output logic                   VGA_SYNC_N,
    output logic                   frame_tick,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int H_TOT_I = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT_I = V_SYNC + V_BP + V_ACTIVE + V_FP;

    generate
        if (H_TOT_I > 1024) begin : g_bad_h
            $error("vga_timing: H_TOTAL exceeds 1024");
        end
        if (V_TOT_I > 1024) begin : g_bad_v
            $error("vga_timing: V_TOTAL exceeds 1024");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_d
            $error("vga_timing: PIPE_DELAY must be 0..4");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT_I - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT_I - 1);
    localparam logic [CNT_W-1:0] H_SYN_W = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYN_W = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_AS_W  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_AE_W  = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_AS_W  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_AE_W  = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic [CNT_W-1:0] hcnt, vcnt;
    sync_t            sync_raw, sync_dly;

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            hcnt       <= '0;
            vcnt       <= '0;
            frame_tick <= 1'b0;
        end else begin
            // Fires on the edge leaving the last pixel of the last visible line's
            // full scan line, so the pulse sits at (0, V_ACT_END+1).
            frame_tick <= (hcnt == H_LAST) && (vcnt == V_AE_W);
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
            end else begin
                hcnt <= hcnt + CNT_W'(1);
            end
        end
    end

    assign VGA_X = hcnt;
    assign VGA_Y = vcnt;

    assign sync_raw.hs      = !(hcnt < H_SYN_W);
    assign sync_raw.vs      = !(vcnt < V_SYN_W);
    assign sync_raw.blank_n = (hcnt >= H_AS_W) && (hcnt <= H_AE_W) &&
                              (vcnt >= V_AS_W) && (vcnt <= V_AE_W);

    // Matches the renderer's registered RGB latency
    vga_sync_delay #(
        .DEPTH   (PIPE_DELAY),
        .WIDTH   ($bits(sync_t)),
        .RST_VAL (SYNC_RST)
    ) u_sync_delay (
        .VGA_CLK (VGA_CLK),
        .reset   (reset),
        .din     (sync_raw),
        .dout    (sync_dly)
    );

    assign VGA_HS      = sync_dly.hs;
    assign VGA_VS      = sync_dly.vs;
    assign VGA_BLANK_N = sync_dly.blank_n;
    assign VGA_SYNC_N  = 1'b0;

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset)           frame_count <= '0;
        else if (frame_tick) frame_count <= frame_count + FRAME_CNT_W'(1);
    end
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;

    logic       clk = 1'b0;
    logic       reset, rst_s;

    logic [9:0]  x, y, xs, ys;
    logic        hs, vs, bn, sn, tick;
    logic        hss, vss, bns, sns, ticks;
    logic [15:0] fc, fcs;

    always #5 clk = ~clk;

    // Full 640x480 timing, PIPE_DELAY=1
    vga_timing dut (
        .VGA_CLK(clk), .reset(reset), .VGA_X(x), .VGA_Y(y),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(bn), .VGA_SYNC_N(sn),
        .frame_tick(tick), .frame_count(fc)
    );

    // Shrunken timing (17x12 = 204 cycles/frame), PIPE_DELAY=2, for frame-level cases
    // Active h 7..14, active v 5..9, tick at (0,10)
    vga_timing #(
        .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(3), .V_ACTIVE(5), .V_FP(2), .PIPE_DELAY(2)
    ) dut_s (
        .VGA_CLK(clk), .reset(rst_s), .VGA_X(xs), .VGA_Y(ys),
        .VGA_HS(hss), .VGA_VS(vss), .VGA_BLANK_N(bns), .VGA_SYNC_N(sns),
        .frame_tick(ticks), .frame_count(fcs)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int cyc;
        int x, y, hs, vs, bn;
    } vec_t;

    vec_t tbl[12];

`ifdef VGA_FRAME_COUNT_EN
    localparam int FC3 = 3;
`else
    localparam int FC3 = 0;
`endif

    initial begin
        int idx, hs_low, hs_first, hs_last, bn_early, rise, fall;
        int nt, last_t, vs_low, bn_tail, first_t;

        // cyc = edges after reset release; outputs reflect raw strobes of cyc-1
        tbl[0]  = '{1,     1,   0,  0, 0, 0};
        tbl[1]  = '{96,    96,  0,  0, 0, 0};
        tbl[2]  = '{97,    97,  0,  1, 0, 0};
        tbl[3]  = '{799,   799, 0,  1, 0, 0};
        tbl[4]  = '{800,   0,   1,  1, 0, 0};
        tbl[5]  = '{801,   1,   1,  0, 0, 0};
        tbl[6]  = '{1601,  1,   2,  0, 1, 0};
        tbl[7]  = '{27700, 500, 34, 1, 1, 0};
        tbl[8]  = '{28144, 144, 35, 1, 1, 0};
        tbl[9]  = '{28145, 145, 35, 1, 1, 1};
        tbl[10] = '{28784, 784, 35, 1, 1, 1};
        tbl[11] = '{28785, 785, 35, 1, 1, 0};

        // Reset state
        reset = 1'b1;
        rst_s = 1'b1;
        repeat (3) step();
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_bn", bn, 0);
        chk("sync_n", sn, 0);
        chk("rst_tick", tick, 0);
        chk("rst_fc", fc, 0);
        reset = 1'b0;

        // Full-size scan: table vectors plus hsync run and line-35 blank edges
        idx = 0; hs_low = 0; hs_first = -1; hs_last = -1;
        bn_early = 0; rise = -1; fall = -1;
        for (int n = 1; n <= 28800; n++) begin
            step();
            if (idx < 12 && tbl[idx].cyc == n) begin
                chk($sformatf("v%0d_x", idx), x, tbl[idx].x);
                chk($sformatf("v%0d_y", idx), y, tbl[idx].y);
                chk($sformatf("v%0d_hs", idx), hs, tbl[idx].hs);
                chk($sformatf("v%0d_vs", idx), vs, tbl[idx].vs);
                chk($sformatf("v%0d_bn", idx), bn, tbl[idx].bn);
                idx++;
            end
            if (n >= 800 && n < 1600 && !hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = n;
                hs_last = n;
            end
            if (n <= 28000 && bn) bn_early++;
            if (rise < 0 && bn) rise = n;
            else if (rise >= 0 && fall < 0 && !bn) fall = n;
            if (tick) chk("no_early_tick", 1, 0);
        end
        chk("tbl_done", idx, 12);
        chk("hs_low_len", hs_low, 96);
        chk("hs_first", hs_first, 801);
        chk("hs_last", hs_last, 896);
        chk("bn_lines0_34", bn_early, 0);
        chk("bn_rise", rise, 28145);
        chk("bn_fall", fall, 28785);
        chk("fc_no_frame", fc, 0);

        // Shrunken instance: 3+ frames of tick, vsync and blank behaviour
        @(negedge clk);
        rst_s = 1'b0;
        nt = 0; last_t = -1; vs_low = 0; bn_tail = 0;
        for (int n = 1; n <= 722; n++) begin
            step();
            if (n == 1) begin
                chk("s_first_x", xs, 1);
                chk("s_first_y", ys, 0);
            end
            if (ticks) begin
                nt++;
                chk("s_tick_x", xs, 0);
                chk("s_tick_y", ys, 10);
                if (last_t >= 0) chk("s_tick_gap", n - last_t, 204);
                else chk("s_tick_first", n, 170);
                last_t = n;
            end
            if (n <= 204 && !vss) vs_low++;
            if (n >= 172 && n <= 205 && bns) bn_tail++;
            if (n == 93) chk("s_bn_pre", bns, 0);
            if (n == 94) chk("s_bn_on", bns, 1);
            if (n == 600) chk("s_fc3", fcs, FC3);
        end
        chk("s_ticks", nt, 3);
        chk("s_vs_low", vs_low, 34);
        chk("s_bn_vblank", bn_tail, 0);
        chk("s_mid_x", xs, 8);
        chk("s_mid_y", ys, 6);

        // Asynchronous reset mid-frame, away from any clock edge
        rst_s = 1'b1;
        #1;
        chk("ar_x", xs, 0);
        chk("ar_y", ys, 0);
        chk("ar_hs", hss, 1);
        chk("ar_vs", vss, 1);
        chk("ar_bn", bns, 0);
        chk("ar_fc", fcs, 0);
        @(negedge clk);
        rst_s = 1'b0;
        step();
        chk("ar_rel_x", xs, 1);
        chk("ar_rel_y", ys, 0);
        first_t = -1;
        for (int n = 2; n <= 300; n++) begin
            step();
            if (ticks && first_t < 0) first_t = n;
        end
        chk("ar_tick_at", first_t, 170);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
